// File: rtl/branch_predictor_bht.sv
// Untagged branch history table with 2-bit saturating counters and a target per entry.
// The lookup is combinational and reads the pre-update state. Statistics counters saturate.
module branch_predictor_bht #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [PC_W-1:0]    tgt_d [ENTRIES];
  logic [CNT_W-1:0]   branch_count_q, branch_count_d;
  logic [CNT_W-1:0]   mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0]   pi;
  logic [IDX_W-1:0]   ui;
  logic [1:0]         upd_base;
  logic               ent_valid;

  // Word-aligned PCs: bits [1:0] and the high bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, upd_pc};

  assign pi        = if_pc[IDX_W+1:2];
  assign ui        = upd_pc[IDX_W+1:2];
  assign ent_valid = valid_q[pi];
  assign upd_base  = valid_q[ui] ? cnt_q[ui] : 2'b01;

  always_comb begin
    pred_taken = 1'b0;
    case (mode)
      2'b01:   pred_taken = ent_valid;
      2'b11:   pred_taken = ent_valid & cnt_q[pi][1];
      default: pred_taken = 1'b0;
    endcase
    pred_target = ent_valid ? tgt_q[pi] : '0;
  end

  always_comb begin
    valid_d         = valid_q;
    cnt_d           = cnt_q;
    tgt_d           = tgt_q;
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_valid) begin
      valid_d[ui] = 1'b1;
      if (upd_taken) begin
        cnt_d[ui] = (upd_base == 2'b11) ? 2'b11 : upd_base + 2'b01;
        tgt_d[ui] = upd_target;
      end else begin
        cnt_d[ui] = (upd_base == 2'b00) ? 2'b00 : upd_base - 2'b01;
      end
      if (branch_count_q != '1)
        branch_count_d = branch_count_q + CNT_W'(1);
      if (upd_mispredict && (mispred_count_q != '1))
        mispred_count_d = mispred_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q         <= '0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      cnt_q           <= cnt_d;
      tgt_q           <= tgt_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign branch_count  = branch_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed testbench for branch_predictor_bht with hand-computed expectations.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [3:0]  branch_count;
  logic [3:0]  mispred_count;

  int checks   = 0;
  int failures = 0;

  branch_predictor_bht #(.ENTRIES(16), .PC_W(32), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .branch_count   (branch_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic mp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mp;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; mode = 2'b11; if_pc = 32'd16;
    // Update presented during reset must be ignored.
    upd_valid = 1'b1; upd_pc = 32'd16; upd_taken = 1'b1; upd_target = 32'd99;
    upd_mispredict = 1'b1;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_taken",   {31'd0, pred_taken}, 32'd0);
    check("reset_target",  pred_target,         32'd0);
    check("reset_bcount",  {28'd0, branch_count},  32'd0);
    check("reset_mcount",  {28'd0, mispred_count}, 32'd0);

    // Hysteresis: T,T,N,N from WNT -> WT,ST,WT,WNT.
    update(32'd16, 1'b1, 32'd88, 1'b0);
    check("hyst_t1_taken", {31'd0, pred_taken}, 32'd1);
    check("hyst_t1_tgt",   pred_target, 32'd88);
    update(32'd16, 1'b1, 32'd88, 1'b0);
    check("hyst_t2_taken", {31'd0, pred_taken}, 32'd1);
    check("hyst_t2_tgt",   pred_target, 32'd88);
    update(32'd16, 1'b0, 32'd5, 1'b0);
    check("hyst_n1_taken", {31'd0, pred_taken}, 32'd1);
    check("hyst_n1_tgt",   pred_target, 32'd88);
    update(32'd16, 1'b0, 32'd5, 1'b0);
    check("hyst_n2_taken", {31'd0, pred_taken}, 32'd0);
    check("hyst_n2_tgt",   pred_target, 32'd88);

    // Aliasing: pc 80 and pc 16 both map to index 4.
    update(32'd16, 1'b1, 32'd88, 1'b0);
    if_pc = 32'd80; #1;
    check("alias_taken", {31'd0, pred_taken}, 32'd1);
    check("alias_tgt",   pred_target, 32'd88);
    update(32'd80, 1'b1, 32'd12, 1'b0);
    if_pc = 32'd16; #1;
    check("alias_back_tgt", pred_target, 32'd12);

    // Modes on a single freshly-trained entry.
    update(32'd28, 1'b1, 32'd12, 1'b0);
    if_pc = 32'd28;
    mode = 2'b00; #1;
    check("mode00_taken", {31'd0, pred_taken}, 32'd0);
    check("mode00_tgt",   pred_target, 32'd12);
    mode = 2'b01; #1;
    check("mode01_taken", {31'd0, pred_taken}, 32'd1);
    check("mode01_tgt",   pred_target, 32'd12);
    mode = 2'b10; #1;
    check("mode10_taken", {31'd0, pred_taken}, 32'd0);
    check("mode10_tgt",   pred_target, 32'd12);
    mode = 2'b11; #1;
    check("mode11_taken", {31'd0, pred_taken}, 32'd1);
    check("mode11_tgt",   pred_target, 32'd12);

    // Same-cycle lookup and update: old state visible until the edge.
    if_pc = 32'd32;
    upd_valid = 1'b1; upd_pc = 32'd32; upd_taken = 1'b1; upd_target = 32'd76;
    #1;
    check("same_before_taken", {31'd0, pred_taken}, 32'd0);
    check("same_before_tgt",   pred_target, 32'd0);
    tick();
    upd_valid = 1'b0;
    #1;
    check("same_after_taken", {31'd0, pred_taken}, 32'd1);
    check("same_after_tgt",   pred_target, 32'd76);

    check("pre_bcount", {28'd0, branch_count},  32'd8);
    check("pre_mcount", {28'd0, mispred_count}, 32'd0);

    // Mid-training reset clears all history.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    if_pc = 32'd16;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m); #1;
      check("post_rst_taken", {31'd0, pred_taken}, 32'd0);
      check("post_rst_tgt",   pred_target, 32'd0);
    end
    mode = 2'b11;

    // Counters: 20 updates, every second one mispredicted.
    for (int i = 0; i < 20; i++)
      update(32'd4, 1'b1, 32'd40, (i % 2) == 1);
    check("cnt_bcount_sat", {28'd0, branch_count},  32'd15);
    check("cnt_mcount",     {28'd0, mispred_count}, 32'd10);
    upd_valid = 1'b0; upd_mispredict = 1'b1;
    tick();
    upd_mispredict = 1'b0;
    check("cnt_idle_bcount", {28'd0, branch_count},  32'd15);
    check("cnt_idle_mcount", {28'd0, mispred_count}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
